decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised successor to the Beta decode stage: full EX/MEM/WB operand bypassing, load-use interlock, stall/annul control and a registered output stage.
- Sits between fetch and ALU.
- Reads the shared register file, resolves branch/jump targets from bypassed operands, and hands a registered instruction, PC and operands to the ALU stage.

Parameters:
- XLEN, 32, datapath width; 32 is the only supported value for the Beta ISA.
- NREGS, 32, number of architectural registers; the highest register index (R31) always reads zero.
- RESET_PC, 32'h8000_0000, reset value of pc_decode.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_plus_four  in  XLEN  fetch PC+4
- inst  in  32  fetched instruction
- fetch_valid  in  1  inst is valid this cycle
- annul  in  1  squash the instruction currently held in decode (taken branch or exception)
- ir_src_dec  in  2  next-IR select: IR_SRC_DATA, IR_SRC_NOP or IR_SRC_EXCEPT
- ex_rc, mem_rc, wb_rc  in  5 each  destination register of the instruction in each later stage
- ex_we, mem_we, wb_we  in  1 each  the instruction in that stage writes rc
- ex_is_ld  in  1  instruction in EX is LD or LDR
- ex_bypass, mem_bypass, wb_bypass  in  XLEN each  result of each later stage
- rf_w_addr  in  5  register-file write address
- rf_w_data  in  XLEN  register-file write data
- rf_we  in  1  register-file write enable
- stall  out  1  hold fetch and decode this cycle
- jump_addr  out  XLEN  jump target: bypassed RA with bits [1:0] cleared
- branch_addr  out  XLEN  branch target: pc_decode + 4·SXT(C)
- zero  out  1  bypassed RA equals 0
- a_reg, b_reg, st_data  out  XLEN each  registered ALU operands and store data
- pc_out, inst_next  out  XLEN, 32  registered PC and instruction for the ALU stage

Behaviour:
- Reset (async, while rst_n=0):
  - pc_decode = RESET_PC; the decode IR holds INST_NOP.
  - inst_next = INST_NOP; a_reg, b_reg, st_data and pc_out are 0; stall = 0.
- Field decode:
  - opcode = [31:26], rc = [25:21], ra = [20:16], rb = [15:11], C = [15:0].
  - Port 2 reads rc for ST and rb otherwise.
- Bypass mux, per read port:
  - Priority order: EX match, then MEM match, then WB match, then register-file data.
  - A stage matches when its we=1, its rc equals the port address, and the address is not 31.
  - R31 reads 0 unconditionally.
  - A register-file write to the same address in the same cycle is covered by the WB bypass path.
- Operand select:
  - a_reg: branch_addr for LDR, bypassed RA otherwise.
  - b_reg: SXT(C) for LD, ST and op-constant instructions; bypassed RD2 otherwise.
  - st_data: bypassed RD2.
- Load-use interlock:
  - Condition: ex_is_ld=1, ex_we=1, and ex_rc matches a port the current instruction actually uses.
  - Response: stall=1 combinationally; decode IR and pc_decode hold; the next inst_next is INST_NOP (bubble).
  - Stall drops one cycle later, when the load reaches MEM and its data arrives through the MEM bypass.
- Decode IR load, evaluated at the clock edge in this priority:
  - annul=1: load INST_NOP. Annul overrides stall.
  - stall=1: hold.
  - fetch_valid=0: load INST_NOP.
  - Otherwise: load inst, and pc_decode loads pc_plus_four.
- Output register, one cycle latency:
  - inst_next: INST_BNE_EXCEPT when ir_src_dec=IR_SRC_EXCEPT.
  - inst_next: INST_NOP when ir_src_dec=IR_SRC_NOP or stall=1.
  - inst_next: the decode IR otherwise.
  - Any other ir_src_dec encoding produces INST_NOP.
- Combinational outputs: zero, jump_addr and branch_addr are same-cycle functions of the decode IR and the bypassed operands.
- Arithmetic: all additions are modulo 2^XLEN; wrap-around is silent.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: full bypass network as described above.
- Undefined: no bypass muxes; operands always come from the register file.
  - stall=1 whenever any EX, MEM or WB stage has we=1 and an rc that matches a used, non-R31 port.
  - Stall persists until the hazard clears.

Decomposition:
- beta_pkg holds:
  - opcode constants;
  - IR_SRC_DATA, IR_SRC_NOP and IR_SRC_EXCEPT;
  - INST_NOP = 32'h83FF_F800;
  - INST_BNE_EXCEPT;
  - register index R31.
- Sub-module bypass_mux (one instance per read port) contains the priority compare-and-select.
- The existing reg_file is instantiated unchanged.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> inst_next = 32'h83FF_F800, pc_out = 0, stall = 0.
- EX bypass: ADDC R1,R31,5 followed immediately by ADD R2,R1,R1, with ex_bypass=5 -> a_reg = 5 and b_reg = 5, with no stall.
- Bypass priority: ex_rc = mem_rc = 3, both we=1, ex_bypass=7, mem_bypass=9, decoding a read of R3 -> operand = 7.
- Load-use: LD R4 in EX, then ADD R5,R4,R4 in decode -> stall=1 for exactly 1 cycle and one NOP inserted; the following cycle uses mem_bypass.
- R31: ex_rc=31, ex_we=1, ex_bypass=0xDEAD, decoding a read of R31 -> operand = 0 and zero = 1.
- Annul during stall: annul=1 and stall=1 together -> next decode IR = NOP; the stall clears.

Source files
------------

// File: rtl/beta_pkg.sv
// beta_pkg: Beta ISA opcodes, instruction constants and IR source selects
// shared by the decode stage and its sub-modules.
package beta_pkg;
   localparam logic [5:0] OP_LD  = 6'h18;
   localparam logic [5:0] OP_ST  = 6'h19;
   localparam logic [5:0] OP_JMP = 6'h1B;
   localparam logic [5:0] OP_BEQ = 6'h1C;
   localparam logic [5:0] OP_BNE = 6'h1D;
   localparam logic [5:0] OP_LDR = 6'h1F;
   localparam logic [1:0] IR_SRC_DATA   = 2'd0;
   localparam logic [1:0] IR_SRC_NOP    = 2'd1;
   localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;
   localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
   localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;
   localparam logic [4:0] R31 = 5'd31;
   function automatic logic [31:0] sxt16(input logic [15:0] c);
      return {{16{c[15]}}, c};
   endfunction
endpackage

// File: rtl/bypass_mux.sv
// bypass_mux: one read port's operand forwarding; EX beats MEM beats WB beats
// register-file data, and R31 always reads zero.
module bypass_mux
   import beta_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      addr_i,
   input  logic [XLEN-1:0] rf_data_i,
   input  logic [4:0]      ex_rc_i,
   input  logic [4:0]      mem_rc_i,
   input  logic [4:0]      wb_rc_i,
   input  logic            ex_we_i,
   input  logic            mem_we_i,
   input  logic            wb_we_i,
   input  logic [XLEN-1:0] ex_data_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] data_o
);
   always_comb
      data_o = (addr_i == R31)                   ? '0         :
               (ex_we_i && ex_rc_i == addr_i)    ? ex_data_i  :
               (mem_we_i && mem_rc_i == addr_i)  ? mem_data_i :
               (wb_we_i && wb_rc_i == addr_i)    ? wb_data_i  : rf_data_i;
endmodule

// File: rtl/reg_file.sv
// reg_file: NREGS x XLEN register file, two asynchronous read ports and one
// synchronous write port; R31 reads zero and ignores writes.
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   input  logic            we,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] mem [NREGS];
   always_ff @(posedge clk)
      if (we && wa != 5'd31) mem[wa] <= wd;
   assign rd1 = (ra1 == 5'd31) ? '0 : mem[ra1];
   assign rd2 = (ra2 == 5'd31) ? '0 : mem[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: Beta decode with operand bypassing, load-use interlock, annul and
// registered ALU hand-off. Define DECODE_BYPASS_EN for the full bypass network.
module decode_stage
   import beta_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_plus_four,
   input  logic [31:0]     inst,
   input  logic            fetch_valid,
   input  logic            annul,
   input  logic [1:0]      ir_src_dec,
   input  logic [4:0]      ex_rc,
   input  logic [4:0]      mem_rc,
   input  logic [4:0]      wb_rc,
   input  logic            ex_we,
   input  logic            mem_we,
   input  logic            wb_we,
   input  logic            ex_is_ld,
   input  logic [XLEN-1:0] ex_bypass,
   input  logic [XLEN-1:0] mem_bypass,
   input  logic [XLEN-1:0] wb_bypass,
   input  logic [4:0]      rf_w_addr,
   input  logic [XLEN-1:0] rf_w_data,
   input  logic            rf_we,
   output logic            stall,
   output logic [XLEN-1:0] jump_addr,
   output logic [XLEN-1:0] branch_addr,
   output logic            zero,
   output logic [XLEN-1:0] a_reg,
   output logic [XLEN-1:0] b_reg,
   output logic [XLEN-1:0] st_data,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     inst_next
);
`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic [31:0]     ir_q, ir_d, inst_next_d;
   logic [XLEN-1:0] pc_q, pc_d, rf_rd1, rf_rd2, rd1, rd2, c_sxt;
   logic [5:0]      opcode;
   logic [4:0]      ra, rd2_addr;
   logic            is_ld, is_st, is_ldr, is_op, is_opc, ra_used, rb_used;
   logic            ex_hit, mem_hit, wb_hit;
   assign opcode   = ir_q[31:26];
   assign ra       = ir_q[20:16];
   assign is_ld    = opcode == OP_LD;
   assign is_st    = opcode == OP_ST;
   assign is_ldr   = opcode == OP_LDR;
   assign is_op    = opcode[5:4] == 2'b10;
   assign is_opc   = opcode[5:4] == 2'b11;
   assign rd2_addr = is_st ? ir_q[25:21] : ir_q[15:11];
   assign ra_used  = is_op || is_opc || is_ld || is_st || opcode == OP_JMP || opcode == OP_BEQ || opcode == OP_BNE;
   assign rb_used  = is_op || is_st;
   assign c_sxt    = XLEN'(sxt16(ir_q[15:0]));
   assign ex_hit   = ex_rc != R31 && ((ra_used && ex_rc == ra) || (rb_used && ex_rc == rd2_addr));
   assign mem_hit  = mem_rc != R31 && ((ra_used && mem_rc == ra) || (rb_used && mem_rc == rd2_addr));
   assign wb_hit   = wb_rc != R31 && ((ra_used && wb_rc == ra) || (rb_used && wb_rc == rd2_addr));
   // Without bypassing every in-flight producer interlocks; with it only a load in EX does.
   assign stall = (ex_we && ex_hit && (ex_is_ld || !BYP)) || (!BYP && ((mem_we && mem_hit) || (wb_we && wb_hit)));
   reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk(clk), .ra1(ra), .ra2(rd2_addr), .wa(rf_w_addr), .wd(rf_w_data), .we(rf_we),
      .rd1(rf_rd1), .rd2(rf_rd2)
   );
   bypass_mux #(.XLEN(XLEN)) u_byp_a (
      .addr_i(ra), .rf_data_i(rf_rd1), .ex_rc_i(ex_rc), .mem_rc_i(mem_rc), .wb_rc_i(wb_rc),
      .ex_we_i(BYP && ex_we), .mem_we_i(BYP && mem_we), .wb_we_i(BYP && wb_we),
      .ex_data_i(ex_bypass), .mem_data_i(mem_bypass), .wb_data_i(wb_bypass), .data_o(rd1)
   );
   bypass_mux #(.XLEN(XLEN)) u_byp_b (
      .addr_i(rd2_addr), .rf_data_i(rf_rd2), .ex_rc_i(ex_rc), .mem_rc_i(mem_rc), .wb_rc_i(wb_rc),
      .ex_we_i(BYP && ex_we), .mem_we_i(BYP && mem_we), .wb_we_i(BYP && wb_we),
      .ex_data_i(ex_bypass), .mem_data_i(mem_bypass), .wb_data_i(wb_bypass), .data_o(rd2)
   );
   assign zero        = rd1 == '0;
   assign jump_addr   = {rd1[XLEN-1:2], 2'b00};
   assign branch_addr = pc_q + (c_sxt << 2);
   always_comb begin
      ir_d        = annul ? INST_NOP : stall ? ir_q : fetch_valid ? inst : INST_NOP;
      pc_d        = (!annul && !stall && fetch_valid) ? pc_plus_four : pc_q;
      inst_next_d = (ir_src_dec == IR_SRC_EXCEPT) ? INST_BNE_EXCEPT :
                    (ir_src_dec == IR_SRC_DATA && !stall) ? ir_q : INST_NOP;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ir_q      <= INST_NOP;
         pc_q      <= RESET_PC;
         inst_next <= INST_NOP;
         a_reg     <= '0;
         b_reg     <= '0;
         st_data   <= '0;
         pc_out    <= '0;
      end else begin
         ir_q      <= ir_d;
         pc_q      <= pc_d;
         inst_next <= inst_next_d;
         a_reg     <= is_ldr ? branch_addr : rd1;
         b_reg     <= (is_ld || is_st || is_opc) ? c_sxt : rd2;
         st_data   <= rd2;
         pc_out    <= pc_q;
      end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage, for both the default build
// and a build with DECODE_BYPASS_EN defined.
module tb_decode_stage;
`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h83FF_F800;
   localparam logic [31:0] EXC = 32'h77DF_0000;
   localparam logic [5:0] LD = 6'h18, ST = 6'h19, JMP = 6'h1B, BEQ = 6'h1C, BNE = 6'h1D, LDR = 6'h1F;
   localparam logic [5:0] ADD = 6'h20, ADDC = 6'h30;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] pc_plus_four, inst, ex_bypass, mem_bypass, wb_bypass, rf_w_data;
   logic        fetch_valid, annul, ex_we, mem_we, wb_we, ex_is_ld, rf_we;
   logic [1:0]  ir_src_dec;
   logic [4:0]  ex_rc, mem_rc, wb_rc, rf_w_addr;
   logic        stall, zero;
   logic [31:0] jump_addr, branch_addr, a_reg, b_reg, st_data, pc_out, inst_next;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .pc_plus_four(pc_plus_four), .inst(inst), .fetch_valid(fetch_valid),
      .annul(annul), .ir_src_dec(ir_src_dec), .ex_rc(ex_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
      .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_ld(ex_is_ld), .ex_bypass(ex_bypass),
      .mem_bypass(mem_bypass), .wb_bypass(wb_bypass), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
      .rf_we(rf_we), .stall(stall), .jump_addr(jump_addr), .branch_addr(branch_addr), .zero(zero),
      .a_reg(a_reg), .b_reg(b_reg), .st_data(st_data), .pc_out(pc_out), .inst_next(inst_next)
   );
   function automatic logic [31:0] f_op(input logic [5:0] o, input logic [4:0] rc, ra, rb);
      return {o, rc, ra, rb, 11'd0};
   endfunction
   function automatic logic [31:0] f_opc(input logic [5:0] o, input logic [4:0] rc, ra, input logic [15:0] c);
      return {o, rc, ra, c};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_stages();
      {ex_we, mem_we, wb_we, ex_is_ld, annul, fetch_valid, rf_we} = '0;
      {ex_rc, mem_rc, wb_rc} = '0;
      {ex_bypass, mem_bypass, wb_bypass} = '0;
      ir_src_dec = 2'd0;
   endtask
   task automatic load(input logic [31:0] i, input logic [31:0] pc4);
      inst = i;
      pc_plus_four = pc4;
      fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
   endtask
   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      rf_w_addr = a;
      rf_w_data = d;
      rf_we = 1'b1;
      tick();
      rf_we = 1'b0;
   endtask
   task automatic test_reset();
      clear_stages();
      inst = 32'h0;
      pc_plus_four = 32'h0;
      rf_w_addr = 5'd0;
      rf_w_data = 32'h0;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL reset_inst_next: got %h want %h", inst_next, NOP); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (a_reg !== 32'h0 || b_reg !== 32'h0 || st_data !== 32'h0) begin failures++; $display("FAIL reset_operands: got %h %h %h want 0", a_reg, b_reg, st_data); end
      checks++; if (branch_addr !== 32'h7FFF_E000) begin failures++; $display("FAIL reset_branch_addr: got %h want 7fffe000", branch_addr); end
      rst_n = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc_decode: got %h want 80000000", pc_out); end
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL idle_inst_next: got %h want %h", inst_next, NOP); end
   endtask
   task automatic test_ex_bypass();
      clear_stages();
      load(f_opc(ADDC, 5'd1, 5'd31, 16'd5), 32'h100);
      load(f_op(ADD, 5'd2, 5'd1, 5'd1), 32'h104);
      checks++; if (a_reg !== 32'd0 || b_reg !== 32'd5) begin failures++; $display("FAIL addc_operands: got %h %h want 0 5", a_reg, b_reg); end
      checks++; if (inst_next !== f_opc(ADDC, 5'd1, 5'd31, 16'd5) || pc_out !== 32'h100) begin failures++; $display("FAIL addc_issue: got %h pc %h want %h pc 100", inst_next, pc_out, f_opc(ADDC, 5'd1, 5'd31, 16'd5)); end
      ex_rc = 5'd1; ex_we = 1'b1; ex_bypass = 32'd5;
      #1;
      checks++; if (stall !== !BYP) begin failures++; $display("FAIL ex_hazard_stall: got %b want %b", stall, !BYP); end
      tick();
`ifdef DECODE_BYPASS_EN
      checks++; if (a_reg !== 32'd5 || b_reg !== 32'd5) begin failures++; $display("FAIL ex_bypass_operands: got %h %h want 5 5", a_reg, b_reg); end
`else
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL ex_hazard_bubble: got %h want %h", inst_next, NOP); end
      ex_we = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ex_hazard_clear: got %b want 0", stall); end
      tick();
      checks++; if (a_reg !== 32'd100 || b_reg !== 32'd100) begin failures++; $display("FAIL rf_operands: got %h %h want 64 64", a_reg, b_reg); end
`endif
      checks++; if (inst_next !== f_op(ADD, 5'd2, 5'd1, 5'd1) || pc_out !== 32'h104) begin failures++; $display("FAIL add_issue: got %h pc %h want %h pc 104", inst_next, pc_out, f_op(ADD, 5'd2, 5'd1, 5'd1)); end
   endtask
   task automatic test_priority();
      clear_stages();
      load(f_op(ADD, 5'd6, 5'd3, 5'd31), 32'h200);
      ex_rc = 5'd3; mem_rc = 5'd3; ex_we = 1'b1; mem_we = 1'b1; ex_bypass = 32'd7; mem_bypass = 32'd9;
      #1;
      checks++; if (stall !== !BYP) begin failures++; $display("FAIL prio_stall: got %b want %b", stall, !BYP); end
`ifdef DECODE_BYPASS_EN
      tick();
      checks++; if (a_reg !== 32'd7) begin failures++; $display("FAIL prio_ex_over_mem: got %h want 7", a_reg); end
      load(f_op(ADD, 5'd6, 5'd3, 5'd31), 32'h204);
      ex_we = 1'b0; wb_rc = 5'd3; wb_we = 1'b1; wb_bypass = 32'd11;
      tick();
      checks++; if (a_reg !== 32'd9) begin failures++; $display("FAIL prio_mem_over_wb: got %h want 9", a_reg); end
      load(f_op(ADD, 5'd6, 5'd3, 5'd31), 32'h208);
      mem_we = 1'b0;
      tick();
      checks++; if (a_reg !== 32'd11) begin failures++; $display("FAIL prio_wb_over_rf: got %h want b", a_reg); end
`else
      tick();
      ex_we = 1'b0; mem_we = 1'b0; wb_rc = 5'd3; wb_we = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wb_hazard_stall: got %b want 1", stall); end
      tick();
      wb_we = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wb_hazard_clear: got %b want 0", stall); end
      tick();
      checks++; if (a_reg !== 32'd300) begin failures++; $display("FAIL prio_rf_read: got %h want 12c", a_reg); end
`endif
      clear_stages();
      load(f_opc(ST, 5'd3, 5'd1, 16'd8), 32'h250);
      ex_rc = 5'd3; ex_we = 1'b1; ex_bypass = 32'd7;
      #1;
      checks++; if (stall !== !BYP) begin failures++; $display("FAIL st_rc_stall: got %b want %b", stall, !BYP); end
      tick();
`ifdef DECODE_BYPASS_EN
      checks++; if (st_data !== 32'd7) begin failures++; $display("FAIL st_data_bypass: got %h want 7", st_data); end
`else
      ex_we = 1'b0;
      tick();
      checks++; if (st_data !== 32'd300) begin failures++; $display("FAIL st_data_rf: got %h want 12c", st_data); end
`endif
      checks++; if (a_reg !== 32'd100 || b_reg !== 32'd8) begin failures++; $display("FAIL st_operands: got %h %h want 64 8", a_reg, b_reg); end
   endtask
   task automatic test_load_use();
      clear_stages();
      load(f_op(ADD, 5'd5, 5'd4, 5'd4), 32'h300);
      inst = f_op(ADD, 5'd9, 5'd1, 5'd1); pc_plus_four = 32'h304; fetch_valid = 1'b1;
      ex_is_ld = 1'b1; ex_we = 1'b1; ex_rc = 5'd4;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_use_stall: got %b want 1", stall); end
      tick();
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL load_use_bubble: got %h want %h", inst_next, NOP); end
      fetch_valid = 1'b0; ex_is_ld = 1'b0; ex_we = 1'b0;
      mem_rc = 5'd4; mem_we = 1'b1; mem_bypass = 32'h44;
      #1;
`ifdef DECODE_BYPASS_EN
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_use_release: got %b want 0", stall); end
      tick();
      checks++; if (a_reg !== 32'h44 || b_reg !== 32'h44) begin failures++; $display("FAIL load_use_mem_bypass: got %h %h want 44 44", a_reg, b_reg); end
`else
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mem_hazard_stall: got %b want 1", stall); end
      tick();
      mem_we = 1'b0; wb_rc = 5'd4; wb_we = 1'b1;
      tick();
      wb_we = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_use_release: got %b want 0", stall); end
      tick();
      checks++; if (a_reg !== 32'd400 || b_reg !== 32'd400) begin failures++; $display("FAIL load_use_rf: got %h %h want 190 190", a_reg, b_reg); end
`endif
      checks++; if (inst_next !== f_op(ADD, 5'd5, 5'd4, 5'd4) || pc_out !== 32'h300) begin failures++; $display("FAIL load_use_held: got %h pc %h want %h pc 300", inst_next, pc_out, f_op(ADD, 5'd5, 5'd4, 5'd4)); end
   endtask
   task automatic test_r31_and_targets();
      clear_stages();
      load(f_opc(BEQ, 5'd28, 5'd31, 16'd3), 32'h400);
      ex_rc = 5'd31; ex_we = 1'b1; ex_bypass = 32'hDEAD;
      #1;
      checks++; if (stall !== 1'b0 || zero !== 1'b1) begin failures++; $display("FAIL r31_zero: got stall %b zero %b want 0 1", stall, zero); end
      checks++; if (jump_addr !== 32'h0 || branch_addr !== 32'h40C) begin failures++; $display("FAIL r31_targets: got %h %h want 0 40c", jump_addr, branch_addr); end
      tick();
      checks++; if (a_reg !== 32'h0) begin failures++; $display("FAIL r31_operand: got %h want 0", a_reg); end
      clear_stages();
      load(f_opc(JMP, 5'd28, 5'd5, 16'd0), 32'h500);
      checks++; if (jump_addr !== 32'h1234 || zero !== 1'b0) begin failures++; $display("FAIL jmp_target: got %h zero %b want 1234 0", jump_addr, zero); end
      load(f_opc(BNE, 5'd28, 5'd31, 16'hFFFF), 32'h600);
      checks++; if (branch_addr !== 32'h5FC) begin failures++; $display("FAIL branch_negative: got %h want 5fc", branch_addr); end
      load(f_opc(BEQ, 5'd28, 5'd31, 16'h0001), 32'hFFFF_FFFC);
      checks++; if (branch_addr !== 32'h0) begin failures++; $display("FAIL branch_wrap: got %h want 0", branch_addr); end
   endtask
   task automatic test_ldr_ld();
      clear_stages();
      load(f_opc(LDR, 5'd8, 5'd4, 16'h0010), 32'h700);
      ex_is_ld = 1'b1; ex_we = 1'b1; ex_rc = 5'd4;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ldr_unused_ra_stall: got %b want 0", stall); end
      tick();
      checks++; if (a_reg !== 32'h740) begin failures++; $display("FAIL ldr_a_reg: got %h want 740", a_reg); end
      clear_stages();
      load(f_opc(LD, 5'd9, 5'd1, 16'hFFF8), 32'h800);
      tick();
      checks++; if (a_reg !== 32'd100 || b_reg !== 32'hFFFF_FFF8) begin failures++; $display("FAIL ld_operands: got %h %h want 64 fffffff8", a_reg, b_reg); end
   endtask
   task automatic test_annul();
      clear_stages();
      load(f_op(ADD, 5'd5, 5'd4, 5'd4), 32'h900);
      ex_is_ld = 1'b1; ex_we = 1'b1; ex_rc = 5'd4;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL annul_pre_stall: got %b want 1", stall); end
      annul = 1'b1;
      tick();
      annul = 1'b0;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL annul_clears_stall: got %b want 0", stall); end
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL annul_bubble: got %h want %h", inst_next, NOP); end
      tick();
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL annul_squashed: got %h want %h", inst_next, NOP); end
   endtask
   task automatic test_ir_src();
      clear_stages();
      load(f_op(ADD, 5'd6, 5'd1, 5'd1), 32'hA00);
      ir_src_dec = 2'd2;
      tick();
      checks++; if (inst_next !== EXC) begin failures++; $display("FAIL ir_src_except: got %h want %h", inst_next, EXC); end
      ir_src_dec = 2'd0;
      load(f_op(ADD, 5'd6, 5'd1, 5'd1), 32'hA04);
      ir_src_dec = 2'd1;
      tick();
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL ir_src_nop: got %h want %h", inst_next, NOP); end
      ir_src_dec = 2'd0;
      load(f_op(ADD, 5'd6, 5'd1, 5'd1), 32'hA08);
      ir_src_dec = 2'd3;
      tick();
      checks++; if (inst_next !== NOP) begin failures++; $display("FAIL ir_src_illegal: got %h want %h", inst_next, NOP); end
      ir_src_dec = 2'd0;
   endtask
   initial begin
      test_reset();
      rf_write(5'd1, 32'd100);
      rf_write(5'd3, 32'd300);
      rf_write(5'd4, 32'd400);
      rf_write(5'd5, 32'h1237);
      test_ex_bypass();
      test_priority();
      test_load_use();
      test_r31_and_targets();
      test_ldr_ld();
      test_annul();
      test_ir_src();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
